// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;

    localparam int FRAME_LEN_W = 16;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_e;

    // Byte address of word number idx, counted from the load base.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0]      base,
                                                    input logic [FRAME_LEN_W-1:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes little-endian into one word and pulses
// word_valid for one cycle in the cycle after the fourth byte arrives.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [1:0]        byte_idx_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    // Lower three bytes of the word under construction; the fourth byte
    // goes straight into word_o together with these.
    logic [WORD_W-BYTE_W-1:0] asm_q;

    // Byte index, partial word, completed word and its one-cycle strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_o   <= 2'd0;
            asm_q        <= '0;
            word_valid_o <= 1'b0;
            word_o       <= '0;
        end else begin
            word_valid_o <= 1'b0;
            if (clr_i) begin
                byte_idx_o <= 2'd0;
                asm_q      <= '0;
            end else if (byte_valid_i) begin
                case (byte_idx_o)
                    2'd0: asm_q[7:0]   <= byte_i;
                    2'd1: asm_q[15:8]  <= byte_i;
                    2'd2: asm_q[23:16] <= byte_i;
                    default: begin
                        // word_o only changes here, so it holds the last
                        // written word while no strobe is pending.
                        word_o       <= {byte_i, asm_q};
                        word_valid_o <= 1'b1;
                        asm_q        <= '0;
                    end
                endcase
                byte_idx_o <= byte_idx_o + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into instruction memory
// one 32-bit word at a time and holds the core stalled while doing so.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   rx_valid_i,
    input  logic [BYTE_W-1:0]      rx_data_i,
    output logic                   rx_ready_o,
    output logic                   imem_we_o,
    output logic [WORD_W-1:0]      imem_addr_o,
    output logic [WORD_W-1:0]      imem_wdata_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [FRAME_LEN_W-1:0] words_o
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    loader_state_e          state_q;
    logic [FRAME_LEN_W-1:0] len_q;     // holds LEN_LO in LEN1, then N
    logic [BYTE_W-1:0]      acc_q;
    logic                   take;
    logic                   start_ok;
    logic                   data_take;
    logic                   last_data_byte;
    logic [FRAME_LEN_W-1:0] len_n;
    logic [1:0]             pk_idx;

    assign take      = rx_valid_i & rx_ready_o;
    assign start_ok  = start_i & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
    assign data_take = take & (state_q == DATA);
    assign len_n     = {rx_data_i, len_q[7:0]};
    // words_o already counts the finished words, so this byte closes word N-1.
    assign last_data_byte = (pk_idx == 2'd3) && ((words_o + 16'd1) == len_q);

    imem_loader_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (start_ok),
        .byte_valid_i (data_take),
        .byte_i       (rx_data_i),
        .byte_idx_o   (pk_idx),
        .word_valid_o (imem_we_o),
        .word_o       (imem_wdata_o)
    );

    // Session FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            len_q      <= '0;
            acc_q      <= '0;
            rx_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q    <= LEN0;
                        acc_q      <= '0;
                        rx_ready_o <= 1'b1;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        err_o      <= 1'b0;
                    end
                end
                LEN0: begin
                    if (take) begin
                        len_q   <= {8'd0, rx_data_i};
                        state_q <= LEN1;
                    end
                end
                LEN1: begin
                    if (take) begin
                        len_q <= len_n;
                        if (len_n == '0) begin
                            state_q <= CHK;
                        end else if ({16'd0, len_n} > DEPTH_U) begin
                            // Oversized frame: refuse it before any write.
                            state_q    <= ERR;
                            rx_ready_o <= 1'b0;
                            busy_o     <= 1'b0;
                            err_o      <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        acc_q <= acc_q ^ rx_data_i;
                        if (last_data_byte) state_q <= CHK;
                    end
                end
                CHK: begin
                    if (take) begin
                        rx_ready_o <= 1'b0;
                        busy_o     <= 1'b0;
                        if (rx_data_i == acc_q) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_o   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rx_ready_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

    // Word counter and write address, updated alongside the packer so they
    // line up with the write strobe one cycle after the fourth byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            words_o     <= '0;
            imem_addr_o <= '0;
        end else if (start_ok) begin
            words_o <= '0;
        end else if (data_take && (pk_idx == 2'd3)) begin
            imem_addr_o <= word_addr(BASE_ADDR, words_o);
            words_o     <= words_o + 16'd1;
        end
    end

endmodule
